// File: rtl/sevenseg_scan_mux.sv
// sevenseg_scan_mux: 6-digit multiplexed seven-segment driver with per-frame snapshot and blinking colon.
// Define LEADING_ZERO_BLANK_EN to blank the hours-tens digit when it is zero.
module sevenseg_scan_mux #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sec_ones,
    input  logic [3:0] sec_tens,
    input  logic [3:0] min_ones,
    input  logic [3:0] min_tens,
    input  logic [3:0] hr_ones,
    input  logic [3:0] hr_tens,
    input  logic       blink_tick,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [3:0]    snap [6];
    logic          colon_on;
    logic          last;
    logic          active;
    logic [3:0]    digit;
    logic [6:0]    dec;
    logic [5:0]    an_n;
    logic [6:0]    seg_n;
    logic          dp_n;

    always_comb begin
        last  = cnt == CW'(SCAN_DIV - 1);
        digit = snap[idx];
`ifdef LEADING_ZERO_BLANK_EN
        active = (cnt >= CW'(BLANK_CYCLES)) && !(idx == 3'd5 && digit == 4'd0);
`else
        active = cnt >= CW'(BLANK_CYCLES);
`endif
        case (digit)
            4'd0:    dec = 7'b1000000;
            4'd1:    dec = 7'b1111001;
            4'd2:    dec = 7'b0100100;
            4'd3:    dec = 7'b0110000;
            4'd4:    dec = 7'b0011001;
            4'd5:    dec = 7'b0010010;
            4'd6:    dec = 7'b0000010;
            4'd7:    dec = 7'b1111000;
            4'd8:    dec = 7'b0000000;
            4'd9:    dec = 7'b0010000;
            default: dec = 7'b0111111;
        endcase
        an_n  = active ? ~(6'b000001 << idx) : 6'b111111;
        seg_n = active ? dec : 7'b1111111;
        dp_n  = !(active && colon_on && (idx == 3'd2 || idx == 3'd4));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            idx      <= 3'd0;
            colon_on <= 1'b0;
            snap     <= '{default: 4'd0};
            an       <= 6'b111111;
            seg      <= 7'b1111111;
            dp       <= 1'b1;
        end else begin
            cnt <= last ? '0 : cnt + 1'b1;
            if (last)
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            // latch the whole time value only on the frame boundary so a frame never tears
            if (last && idx == 3'd5)
                snap <= '{sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens};
            if (blink_tick)
                colon_on <= ~colon_on;
            an  <= an_n;
            seg <= seg_n;
            dp  <= dp_n;
        end
    end
endmodule

// File: tb/tb_sevenseg_scan_mux.sv
// tb_sevenseg_scan_mux: directed frame-by-frame checks of the scan mux with SCAN_DIV=8, BLANK_CYCLES=2.
module tb_sevenseg_scan_mux;
    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] tin;
    logic        blink_tick;
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        dp;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          fr      = 0;

    logic [6:0] pat [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                            7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

    sevenseg_scan_mux #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .sec_ones(tin[3:0]), .sec_tens(tin[7:4]),
        .min_ones(tin[11:8]), .min_tens(tin[15:12]),
        .hr_ones(tin[19:16]), .hr_tens(tin[23:20]),
        .blink_tick(blink_tick), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // exp holds hr_tens..sec_ones as packed BCD; one frame starts right after a frame boundary
    task automatic run_frame(input logic [23:0] exp, input logic col, input int chg,
                             input logic [23:0] nxt, input int b0, input int b1);
        for (int t = 0; t < 48; t++) begin
            int         c;
            int         i;
            logic [3:0] d;
            logic       act;
            logic [5:0] ea;
            logic [6:0] es;
            logic       ed;
            @(negedge clk);
            c   = t % 8;
            i   = t / 8;
            d   = exp[4*i +: 4];
            act = c >= 2;
`ifdef LEADING_ZERO_BLANK_EN
            if (i == 5 && d == 4'd0) act = 1'b0;
`endif
            ea = act ? ~(6'b000001 << i) : 6'b111111;
            es = act ? pat[d] : 7'b1111111;
            ed = !(act && col && (i == 2 || i == 4));
            check($sformatf("an f%0d t%0d", fr, t), {26'd0, an}, {26'd0, ea});
            check($sformatf("seg f%0d t%0d", fr, t), {25'd0, seg}, {25'd0, es});
            check($sformatf("dp f%0d t%0d", fr, t), {31'd0, dp}, {31'd0, ed});
            if (t == chg) tin = nxt;
            blink_tick = (t == b0 || t == b1);
        end
        fr++;
    endtask

    task automatic check_reset(input string tag);
        check({tag, " an"}, {26'd0, an}, 32'h3f);
        check({tag, " seg"}, {25'd0, seg}, 32'h7f);
        check({tag, " dp"}, {31'd0, dp}, 32'h1);
    endtask

    initial begin
        rst        = 1'b1;
        tin        = 24'h0;
        blink_tick = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        run_frame(24'h000000, 1'b0, 0,  24'h123456, -1, -1);
        run_frame(24'h123456, 1'b0, -1, 24'h0,      -1, -1);
        run_frame(24'h123456, 1'b0, 0,  24'h000009, -1, -1);
        run_frame(24'h000009, 1'b0, 20, 24'h000010, -1, -1);
        run_frame(24'h000010, 1'b0, 0,  24'h00000C, -1, -1);
        run_frame(24'h00000C, 1'b0, -1, 24'h0,      47, -1);
        run_frame(24'h00000C, 1'b1, -1, 24'h0,      47, -1);
        run_frame(24'h00000C, 1'b0, -1, 24'h0,      45, 46);
        run_frame(24'h00000C, 1'b0, -1, 24'h0,      -1, -1);
        rst        = 1'b1;
        blink_tick = 1'b1;
        @(negedge clk);
        blink_tick = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("reset2");
        rst = 1'b0;
        run_frame(24'h000000, 1'b0, -1, 24'h0, -1, -1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sevenseg_scan_mux.md
Name: sevenseg_scan_mux

Overview:
- Display stage directly downstream of the BCD time counters. It consumes six BCD digits (HH:MM:SS) and drives a 6-digit multiplexed seven-segment display.
- Time-multiplexes the anodes, decodes BCD to segments, and blinks the colon decimal points once per second.
- Takes a snapshot of the digits once per full scan so that a count update mid-scan does not tear the display.

Parameters:
- SCAN_DIV, 50000, clk cycles each digit stays selected; legal range >= 4.
- BLANK_CYCLES, 16, anti-ghosting cycles at the start of each digit slot with all anodes off; must be < SCAN_DIV.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- sec_ones  in  4  BCD seconds units.
- sec_tens  in  4  BCD seconds tens.
- min_ones  in  4  BCD minutes units.
- min_tens  in  4  BCD minutes tens.
- hr_ones  in  4  BCD hours units.
- hr_tens  in  4  BCD hours tens.
- blink_tick  in  1  one-cycle pulse, 1 per second (seconds-counter enable/carry); toggles the colon.
- an  out  6  anode enables, active-low; bit i selects digit i (0 = sec_ones ... 5 = hr_tens).
- seg  out  7  segments, active-low, order {g,f,e,d,c,b,a}.
- dp  out  1  decimal point, active-low.

Behaviour:
- Reset (rst=1 at a clk edge):
  - an=6'b111111, seg=7'b1111111, dp=1.
  - cnt=0, idx=0, colon_on=0.
  - Snapshot registers = 0.
  - rst has priority over every other event, including blink_tick.
- Slot counter:
  - cnt counts 0..SCAN_DIV-1 on every clk.
  - At cnt==SCAN_DIV-1: cnt<=0 and idx<=idx+1, wrapping 5->0.
- Snapshot:
  - At cnt==SCAN_DIV-1 with idx==5 (entering idx 0), all six inputs are latched together.
  - Inputs are ignored at all other times.
  - A full frame therefore shows one coherent time value.
- Output registers (updated every clk from the current cnt/idx/snapshot; visible 1 clk later):
  - While cnt<BLANK_CYCLES: an=all 1, seg=all 1, dp=1.
  - Otherwise: an = all 1 except bit idx =0; seg = decode(snapshot digit idx).
- Decode patterns (active-low, 1=off, order g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any value 10-15 shows a dash: 0111111 (g only lit).
- Colon:
  - colon_on toggles on each cycle with blink_tick=1.
  - dp=0 during the active part of idx 2 and idx 4 when colon_on=1; otherwise dp=1.
  - blink_tick pulses closer together than one frame are all counted; no pulse is lost.
- Frame period = 6*SCAN_DIV cycles. Exactly one anode is low at any time, or none during blanking.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when snapshot hr_tens==0, digit 5 is blank for its whole slot. an[5] stays 1, seg=1111111, dp=1. The slot timing is unchanged.
- Not defined: digit 5 is always displayed, including "0".

Test Plan (SCAN_DIV=8, BLANK_CYCLES=2):
- Reset held 3 cycles, then released:
  - During reset: an=111111, seg=1111111, dp=1.
  - After release: the first active slot shows idx 0, an=111110, seg=1000000 at cycle 3 after release.
- Inputs 12:34:56 held for 2 frames:
  - Second frame shows, per digit, sec_ones..hr_tens = 6,5,4,3,2,1.
  - Matching segment patterns: 0000010, 0010010, 0011001, 0110000, 0100100, 1111001.
  - Each digit is active for 6 cycles after a 2-cycle all-off gap.
- Inputs changed from 00:00:09 to 00:00:10 while idx=2 mid-frame:
  - The remainder of the frame still shows 9 on digit 0.
  - The new value appears only from the next frame.
- sec_ones=4'hC:
  - Digit 0 shows 0111111.
- blink_tick pulses twice:
  - After the first pulse, dp=0 only in the active cycles of idx 2 and idx 4.
  - After the second pulse, dp=1 everywhere.
  - Asserting rst in the same cycle as a blink_tick leaves colon_on=0.
- With LEADING_ZERO_BLANK_EN defined and hr_tens=0:
  - an[5] never goes low.
  - With hr_tens=1, an[5] goes low with seg=1111001.
